ysyx_22041207_ifu: RTL and testbench

Instruction fetch unit: owns the fetch PC, issues one-outstanding fetch requests to instruction memory and presents fetched instruction/PC pairs to the IF/ID pipeline register. It is the producer end of the IF/ID interface. It honours the same `bubble` stall that freezes IF/ID and takes branch/jump redirects from later stages. A one-entry skid buffer absorbs a response that arrives while the output slot is stalled.

---
 rtl/ysyx_22041207_ifu_pkg.sv | 30 +++
 rtl/ysyx_22041207_ifu_skid.sv | 51 +++++
 rtl/ysyx_22041207_ifu.sv | 155 +++++++++++++++
 tb/tb_ysyx_22041207_ifu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// reset PC, kill NOP and PC helper functions.
package ysyx_22041207_ifu_pkg;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  typedef enum logic [1:0] {
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_FULL = ST_FULL,
    S_DROP = ST_DROP
  } ifu_state_e;

  // Sequential fetch step; wraps modulo 2^64.
  function automatic logic [63:0] pc_incr(input logic [63:0] p);
    return p + 64'd4;
  endfunction

  // Force word alignment by clearing the two low bits.
  function automatic logic [63:0] pc_align(input logic [63:0] p);
    return p & ~64'd3;
  endfunction

endpackage

// File: rtl/ysyx_22041207_ifu_skid.sv
// One-entry inst/pc holding buffer for a response that arrives while the
// IF/ID slot is stalled. Clear wins over load, load wins over drain.
import ysyx_22041207_ifu_pkg::*;

module ysyx_22041207_ifu_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_inst,
  input  logic [63:0] load_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [63:0] pc
);

  logic        valid_r;
  logic [31:0] inst_r;
  logic [63:0] pc_r;

  // Buffer contents and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      inst_r  <= NOP_INST;
      pc_r    <= RESET_PC;
    end else if (clear) begin
      valid_r <= 1'b0;
      inst_r  <= NOP_INST;
      pc_r    <= pc_r;
    end else if (load) begin
      valid_r <= 1'b1;
      inst_r  <= load_inst;
      pc_r    <= load_pc;
    end else if (drain) begin
      valid_r <= 1'b0;
      inst_r  <= inst_r;
      pc_r    <= pc_r;
    end else begin
      valid_r <= valid_r;
      inst_r  <= inst_r;
      pc_r    <= pc_r;
    end
  end

  assign valid = valid_r;
  assign inst  = inst_r;
  assign pc    = pc_r;

endmodule

// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: owns fetch_pc, keeps one request outstanding to
// instruction memory and drives the IF/ID slot, with a one-entry skid.
import ysyx_22041207_ifu_pkg::*;

module ysyx_22041207_ifu (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic        inst_valid
);

  ifu_state_e  state_r, state_nxt_s;
  logic [63:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [31:0] inst_r, inst_nxt_s;
  logic [63:0] pc_r, pc_nxt_s;
  logic        inst_valid_r, inst_valid_nxt_s;

  logic        consume_s;
  logic        slot_free_s;
  logic        accept_s;
  logic        req_valid_s;

  logic        skid_load_s;
  logic        skid_drain_s;
  logic        skid_clear_s;
  logic        skid_valid_s;
  logic [31:0] skid_inst_s;
  logic [63:0] skid_pc_s;

  assign req_valid_s = (state_r == S_REQ);
  assign consume_s   = inst_valid_r & ~bubble;
  assign slot_free_s = ~inst_valid_r | consume_s;
  assign accept_s    = req_valid_s & req_ready;

  ysyx_22041207_ifu_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load_s),
    .drain     (skid_drain_s),
    .clear     (skid_clear_s),
    .load_inst (resp_data),
    .load_pc   (fetch_pc_r),
    .valid     (skid_valid_s),
    .inst      (skid_inst_s),
    .pc        (skid_pc_s)
  );

  // Next-state, slot update and skid control; redirect overrides everything.
  always_comb begin
    state_nxt_s      = state_r;
    fetch_pc_nxt_s   = fetch_pc_r;
    inst_nxt_s       = inst_r;
    pc_nxt_s         = pc_r;
    inst_valid_nxt_s = consume_s ? 1'b0 : inst_valid_r;
    skid_load_s      = 1'b0;
    skid_drain_s     = 1'b0;
    skid_clear_s     = 1'b0;

    if (redirect) begin
      inst_valid_nxt_s = 1'b0;
      inst_nxt_s       = NOP_INST;
      skid_clear_s     = 1'b1;
      fetch_pc_nxt_s   = pc_align(redirect_pc);
      // Land in DROP only if a request is still in flight after this edge.
      case (state_r)
        S_REQ:   state_nxt_s = accept_s   ? S_DROP : S_REQ;
        S_WAIT:  state_nxt_s = resp_valid ? S_REQ  : S_DROP;
        S_FULL:  state_nxt_s = S_REQ;
        S_DROP:  state_nxt_s = resp_valid ? S_REQ  : S_DROP;
        default: state_nxt_s = S_REQ;
      endcase
    end else begin
      case (state_r)
        S_REQ: begin
          if (accept_s) begin
            state_nxt_s = S_WAIT;
          end else begin
            state_nxt_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (resp_valid && slot_free_s) begin
            inst_nxt_s       = resp_data;
            pc_nxt_s         = fetch_pc_r;
            inst_valid_nxt_s = 1'b1;
            fetch_pc_nxt_s   = pc_incr(fetch_pc_r);
            state_nxt_s      = S_REQ;
          end else if (resp_valid) begin
            skid_load_s    = 1'b1;
            fetch_pc_nxt_s = pc_incr(fetch_pc_r);
            state_nxt_s    = S_FULL;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_FULL: begin
          if (slot_free_s && skid_valid_s) begin
            inst_nxt_s       = skid_inst_s;
            pc_nxt_s         = skid_pc_s;
            inst_valid_nxt_s = 1'b1;
            skid_drain_s     = 1'b1;
            state_nxt_s      = S_REQ;
          end else if (slot_free_s) begin
            state_nxt_s = S_REQ;
          end else begin
            state_nxt_s = S_FULL;
          end
        end
        S_DROP: begin
          if (resp_valid) begin
            state_nxt_s = S_REQ;
          end else begin
            state_nxt_s = S_DROP;
          end
        end
        default: begin
          state_nxt_s = S_REQ;
        end
      endcase
    end
  end

  // State, fetch PC and the registered IF/ID slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_REQ;
      fetch_pc_r   <= RESET_PC;
      inst_r       <= NOP_INST;
      pc_r         <= RESET_PC;
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fetch_pc_r   <= fetch_pc_nxt_s;
      inst_r       <= inst_nxt_s;
      pc_r         <= pc_nxt_s;
      inst_valid_r <= inst_valid_nxt_s;
    end
  end

  assign req_valid  = req_valid_s;
  assign req_addr   = fetch_pc_r;
  assign inst       = inst_r;
  assign pc         = pc_r;
  assign inst_valid = inst_valid_r;

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Directed table-driven bench for the fetch unit with a 1-cycle memory model
// plus hand sequences for redirect, wrap and async reset corners.
module tb_ysyx_22041207_ifu;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        bubble;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_valid;

  int checks;
  int failures;
  logic mem_auto;

  ysyx_22041207_ifu dut (
    .clk         (clk),
    .rst         (rst),
    .bubble      (bubble),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .inst        (inst),
    .pc          (pc),
    .inst_valid  (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_5A5A;
  endfunction

  typedef struct {
    logic        bub;
    logic        rdy;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_iv;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  function automatic vec_t mk(input logic b, input logic r, input logic rv,
                              input logic [63:0] ad, input logic iv,
                              input logic [63:0] p, input logic [31:0] ins);
    vec_t v;
    v.bub = b; v.rdy = r; v.exp_rv = rv; v.exp_addr = ad;
    v.exp_iv = iv; v.exp_pc = p; v.exp_inst = ins;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One clock; the memory model answers one cycle after an accept.
  task automatic cycle();
    logic        acc;
    logic [63:0] a;
    acc = req_valid & req_ready;
    a   = req_addr;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      resp_valid = acc;
      resp_data  = dat(a);
    end
  endtask

  task automatic chk_all(input string nm, input logic rv, input logic [63:0] ad,
                         input logic iv, input logic [63:0] p, input logic [31:0] ins);
    chk({nm, ".req_valid"}, {63'd0, req_valid}, {63'd0, rv});
    chk({nm, ".req_addr"}, req_addr, ad);
    chk({nm, ".inst_valid"}, {63'd0, inst_valid}, {63'd0, iv});
    chk({nm, ".pc"}, pc, p);
    chk({nm, ".inst"}, {32'd0, inst}, {32'd0, ins});
  endtask

  vec_t vt[18];

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; bubble = 1'b0; redirect = 1'b0; redirect_pc = 64'd0;
    req_ready = 1'b1; resp_valid = 1'b0; resp_data = 32'd0; mem_auto = 1'b1;

    vt[0]  = mk(1'b0, 1'b1, 1'b0, RPC,          1'b0, RPC,          NOP);
    vt[1]  = mk(1'b0, 1'b1, 1'b1, RPC + 64'h4,  1'b1, RPC,          dat(RPC));
    vt[2]  = mk(1'b0, 1'b1, 1'b0, RPC + 64'h4,  1'b0, RPC,          dat(RPC));
    vt[3]  = mk(1'b0, 1'b1, 1'b1, RPC + 64'h8,  1'b1, RPC + 64'h4,  dat(RPC + 64'h4));
    vt[4]  = mk(1'b1, 1'b1, 1'b0, RPC + 64'h8,  1'b1, RPC + 64'h4,  dat(RPC + 64'h4));
    vt[5]  = mk(1'b1, 1'b1, 1'b0, RPC + 64'hC,  1'b1, RPC + 64'h4,  dat(RPC + 64'h4));
    vt[6]  = mk(1'b1, 1'b1, 1'b0, RPC + 64'hC,  1'b1, RPC + 64'h4,  dat(RPC + 64'h4));
    vt[7]  = mk(1'b1, 1'b1, 1'b0, RPC + 64'hC,  1'b1, RPC + 64'h4,  dat(RPC + 64'h4));
    vt[8]  = mk(1'b1, 1'b1, 1'b0, RPC + 64'hC,  1'b1, RPC + 64'h4,  dat(RPC + 64'h4));
    vt[9]  = mk(1'b0, 1'b1, 1'b1, RPC + 64'hC,  1'b1, RPC + 64'h8,  dat(RPC + 64'h8));
    vt[10] = mk(1'b0, 1'b1, 1'b0, RPC + 64'hC,  1'b0, RPC + 64'h8,  dat(RPC + 64'h8));
    vt[11] = mk(1'b0, 1'b1, 1'b1, RPC + 64'h10, 1'b1, RPC + 64'hC,  dat(RPC + 64'hC));
    vt[12] = mk(1'b0, 1'b0, 1'b1, RPC + 64'h10, 1'b0, RPC + 64'hC,  dat(RPC + 64'hC));
    vt[13] = mk(1'b0, 1'b0, 1'b1, RPC + 64'h10, 1'b0, RPC + 64'hC,  dat(RPC + 64'hC));
    vt[14] = mk(1'b0, 1'b0, 1'b1, RPC + 64'h10, 1'b0, RPC + 64'hC,  dat(RPC + 64'hC));
    vt[15] = mk(1'b0, 1'b0, 1'b1, RPC + 64'h10, 1'b0, RPC + 64'hC,  dat(RPC + 64'hC));
    vt[16] = mk(1'b0, 1'b1, 1'b0, RPC + 64'h10, 1'b0, RPC + 64'hC,  dat(RPC + 64'hC));
    vt[17] = mk(1'b0, 1'b1, 1'b1, RPC + 64'h14, 1'b1, RPC + 64'h10, dat(RPC + 64'h10));

    // Reset state while rst is held.
    @(posedge clk); #1;
    chk_all("reset", 1'b1, RPC, 1'b0, RPC, NOP);
    @(negedge clk);
    rst = 1'b0;

    // Free run, skid stall, backpressure.
    for (int i = 0; i < 18; i++) begin
      bubble    = vt[i].bub;
      req_ready = vt[i].rdy;
      cycle();
      chk_all($sformatf("vec%0d", i), vt[i].exp_rv, vt[i].exp_addr,
              vt[i].exp_iv, vt[i].exp_pc, vt[i].exp_inst);
    end

    // Redirect in WAIT with no response yet -> DROP, stale response discarded.
    mem_auto = 1'b0; resp_valid = 1'b0; bubble = 1'b0; req_ready = 1'b1;
    cycle();
    chk("rdw.wait_rv", {63'd0, req_valid}, 64'd0);
    redirect = 1'b1; redirect_pc = 64'h0000_0000_8000_1003;
    cycle();
    chk_all("rdw.drop", 1'b0, 64'h8000_1000, 1'b0, RPC + 64'h10, NOP);
    redirect = 1'b0; resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF;
    cycle();
    chk_all("rdw.discard", 1'b1, 64'h8000_1000, 1'b0, RPC + 64'h10, NOP);
    resp_valid = 1'b0; mem_auto = 1'b1;
    cycle();
    cycle();
    chk_all("rdw.refetch", 1'b1, 64'h8000_1004, 1'b1, 64'h8000_1000, dat(64'h8000_1000));

    // Redirect on the same edge as an accept -> DROP.
    redirect = 1'b1; redirect_pc = 64'h0000_0000_8000_2000;
    cycle();
    chk("rda.rv", {63'd0, req_valid}, 64'd0);
    chk("rda.addr", req_addr, 64'h8000_2000);
    chk("rda.iv", {63'd0, inst_valid}, 64'd0);
    redirect = 1'b0;
    cycle();
    chk("rda.after_rv", {63'd0, req_valid}, 64'd1);
    chk("rda.after_iv", {63'd0, inst_valid}, 64'd0);

    // Redirect on the same edge as a response -> data dropped, REQ at new PC.
    cycle();
    redirect = 1'b1; redirect_pc = 64'h0000_0000_8000_3000;
    cycle();
    chk_all("rdr", 1'b1, 64'h8000_3000, 1'b0, 64'h8000_1000, NOP);

    // Address wrap past the top of the 64-bit space.
    req_ready = 1'b0; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    chk("wrap.addr0", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    redirect = 1'b0; req_ready = 1'b1;
    cycle();
    cycle();
    chk_all("wrap", 1'b1, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, dat(64'hFFFF_FFFF_FFFF_FFFC));

    // Reach FULL under stall, then assert reset between edges.
    bubble = 1'b1;
    cycle();
    cycle();
    chk_all("full", 1'b0, 64'h4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, dat(64'hFFFF_FFFF_FFFF_FFFC));
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b1, RPC, 1'b0, RPC, NOP);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
